// File: rtl/rr_pulse_arbiter_if.sv
// -----------------------------------------------------------------------------
// rr_pulse_arbiter_if
//   Bundles the arbitration trigger, request vector and grant/statistics
//   outputs of rr_pulse_arbiter into a single interface.
// Signals
//   go          trigger; only its rising edge starts an arbitration
//   req         N-bit request vector, sampled at the go-rise edge
//   clr_stats   synchronous clear of grant_total/miss_total
//   grant       one-hot combinational grant, valid only in the go-rise cycle
//   grant_vld   registered: a grant was issued in the previous cycle
//   grant_idx   registered: index granted in the previous cycle (0 if none)
//   ptr         registered: index holding the next turn
//   miss        registered pulse: previous go rise found its turn owner idle
//   grant_total saturating count of grants issued
//   miss_total  saturating count of missed turns
// Modports
//   master  drives go/req/clr_stats, observes results
//   slave   the arbiter side
// -----------------------------------------------------------------------------
interface rr_pulse_arbiter_if #(
    parameter int N     = 8,
    parameter int PTR_W = $clog2(N),
    parameter int CNT_W = 16
);
    logic             go;
    logic [N-1:0]     req;
    logic             clr_stats;
    logic [N-1:0]     grant;
    logic             grant_vld;
    logic [PTR_W-1:0] grant_idx;
    logic [PTR_W-1:0] ptr;
    logic             miss;
    logic [CNT_W-1:0] grant_total;
    logic [CNT_W-1:0] miss_total;

    modport master (
        output go, req, clr_stats,
        input  grant, grant_vld, grant_idx, ptr, miss, grant_total, miss_total
    );

    modport slave (
        input  go, req, clr_stats,
        output grant, grant_vld, grant_idx, ptr, miss, grant_total, miss_total
    );
endinterface

// File: rtl/rr_pulse_arbiter.sv
// -----------------------------------------------------------------------------
// rr_pulse_arbiter
//   Round-robin arbiter for N requesters, advanced by the rising edge of go.
//   On each go rise the turn owner (ptr) is granted if it requests, otherwise
//   the turn is recorded as a miss. The turn always advances, wrapping N-1 -> 0.
// Ports
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      rr_pulse_arbiter_if.slave (go/req/clr_stats in; grant, grant_vld,
//            grant_idx, ptr, miss, grant_total, miss_total out)
// -----------------------------------------------------------------------------
module rr_pulse_arbiter #(
    parameter int N     = 8,
    parameter int PTR_W = $clog2(N),
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    rr_pulse_arbiter_if.slave   bus
);

    logic             r_go_d;
    logic [PTR_W-1:0] r_ptr;
    logic             r_grant_vld;
    logic [PTR_W-1:0] r_grant_idx;
    logic             r_miss;
    logic [CNT_W-1:0] r_grant_total;
    logic [CNT_W-1:0] r_miss_total;

    logic             w_rise;
    logic             w_req_cur;
    logic             w_hit;
    logic             w_idle;
    logic [PTR_W-1:0] w_ptr_next;
    logic [N-1:0]     w_grant;

    assign w_rise    = bus.go & ~r_go_d;
    assign w_req_cur = bus.req[r_ptr];
    assign w_hit     = w_rise & w_req_cur;
    assign w_idle    = w_rise & ~w_req_cur;

    // Explicit compare keeps the wrap correct for non-power-of-2 N.
    assign w_ptr_next = (r_ptr == PTR_W'(N - 1)) ? '0 : r_ptr + PTR_W'(1);

    // Grant is gated by reset_n so it is silent while reset is asserted,
    // even if go is high and go_d has just been cleared.
    always_comb begin
        w_grant = '0;
        if (reset_n && w_hit) begin
            w_grant[r_ptr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_go_d      <= 1'b0;
            r_ptr       <= '0;
            r_grant_vld <= 1'b0;
            r_grant_idx <= '0;
            r_miss      <= 1'b0;
        end else begin
            r_go_d      <= bus.go;
            r_grant_vld <= w_hit;
            r_grant_idx <= w_hit ? r_ptr : '0;
            r_miss      <= w_idle;
            if (w_rise) begin
                r_ptr <= w_ptr_next;
            end
        end
    end

    // Saturating statistics; clear takes priority over a coincident increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_grant_total <= '0;
            r_miss_total  <= '0;
        end else if (bus.clr_stats) begin
            r_grant_total <= '0;
            r_miss_total  <= '0;
        end else begin
            if (w_hit && (r_grant_total != '1)) begin
                r_grant_total <= r_grant_total + CNT_W'(1);
            end
            if (w_idle && (r_miss_total != '1)) begin
                r_miss_total <= r_miss_total + CNT_W'(1);
            end
        end
    end

    assign bus.grant       = w_grant;
    assign bus.grant_vld   = r_grant_vld;
    assign bus.grant_idx   = r_grant_idx;
    assign bus.ptr         = r_ptr;
    assign bus.miss        = r_miss;
    assign bus.grant_total = r_grant_total;
    assign bus.miss_total  = r_miss_total;

endmodule

// File: tb/tb_rr_pulse_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_pulse_arbiter
//   Directed and random stimulus for rr_pulse_arbiter. A reference model
//   predicts the combinational grant immediately and queues the expected
//   registered outputs, which are popped and compared after the next edge.
//   Counters are built 4 bits wide so saturation is reachable quickly.
// -----------------------------------------------------------------------------
module tb_rr_pulse_arbiter;

    localparam int N     = 8;
    localparam int PTR_W = 3;
    localparam int CNT_W = 4;

    logic clk;
    logic reset_n;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic             vld;
        logic [PTR_W-1:0] idx;
        logic             miss;
        logic [PTR_W-1:0] ptr;
        logic [CNT_W-1:0] gt;
        logic [CNT_W-1:0] mt;
    } exp_t;

    exp_t exp_q[$];

    // reference model state (value expected after the most recent edge)
    logic             m_god;
    logic [PTR_W-1:0] m_ptr;
    logic [CNT_W-1:0] m_gt;
    logic [CNT_W-1:0] m_mt;

    rr_pulse_arbiter_if #(.N(N), .PTR_W(PTR_W), .CNT_W(CNT_W)) bus ();

    rr_pulse_arbiter #(.N(N), .PTR_W(PTR_W), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_god = 1'b0;
        m_ptr = '0;
        m_gt  = '0;
        m_mt  = '0;
        exp_q.delete();
    endtask

    // Inputs already applied: check grant now, queue post-edge expectations.
    task automatic predict();
        logic         rise;
        logic         hit;
        logic         rq;
        logic [N-1:0] eg;
        exp_t         e;
        rise = bus.go & ~m_god;
        rq   = bus.req[m_ptr];
        hit  = rise & rq;
        eg   = '0;
        if (hit) eg[m_ptr] = 1'b1;
        chk("grant", 32'(bus.grant), 32'(eg));
        e.vld  = hit;
        e.idx  = hit ? m_ptr : '0;
        e.miss = rise & ~rq;
        if (rise) m_ptr = (m_ptr == PTR_W'(N - 1)) ? '0 : m_ptr + PTR_W'(1);
        if (bus.clr_stats) begin
            m_gt = '0;
            m_mt = '0;
        end else begin
            if (hit && m_gt != '1) m_gt = m_gt + CNT_W'(1);
            if (rise && !rq && m_mt != '1) m_mt = m_mt + CNT_W'(1);
        end
        m_god = bus.go;
        e.ptr = m_ptr;
        e.gt  = m_gt;
        e.mt  = m_mt;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic g, input logic [N-1:0] r, input logic c);
        @(negedge clk);
        bus.go        = g;
        bus.req       = r;
        bus.clr_stats = c;
        #1;
        predict();
    endtask

    task automatic settle();
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'(1), 32'(0));
        end else begin
            e = exp_q.pop_front();
            chk("grant_vld",   32'(bus.grant_vld),   32'(e.vld));
            chk("grant_idx",   32'(bus.grant_idx),   32'(e.idx));
            chk("miss",        32'(bus.miss),        32'(e.miss));
            chk("ptr",         32'(bus.ptr),         32'(e.ptr));
            chk("grant_total", 32'(bus.grant_total), 32'(e.gt));
            chk("miss_total",  32'(bus.miss_total),  32'(e.mt));
        end
    endtask

    task automatic cyc(input logic g, input logic [N-1:0] r, input logic c);
        drive(g, r, c);
        settle();
    endtask

    task automatic pulse(input logic [N-1:0] r);
        cyc(1'b1, r, 1'b0);
        cyc(1'b0, r, 1'b0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_grant"},     32'(bus.grant),       32'(0));
        chk({tag, "_ptr"},       32'(bus.ptr),         32'(0));
        chk({tag, "_grant_vld"}, 32'(bus.grant_vld),   32'(0));
        chk({tag, "_grant_idx"}, 32'(bus.grant_idx),   32'(0));
        chk({tag, "_miss"},      32'(bus.miss),        32'(0));
        chk({tag, "_gtotal"},    32'(bus.grant_total), 32'(0));
        chk({tag, "_mtotal"},    32'(bus.miss_total),  32'(0));
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.go        = 1'b0;
        bus.req       = '0;
        bus.clr_stats = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk_reset_state("rst");
        @(negedge clk);
        reset_n = 1'b1;

        // 1: all requesting, 10 pulses -> 01,02,..,80,01,02; ptr ends at 2
        for (int unsigned i = 0; i < 10; i++) pulse(8'hFF);
        chk("t1_ptr_end", 32'(bus.ptr), 32'(2));

        // bring ptr back to 0 with idle pulses, then clear statistics
        for (int unsigned i = 0; i < 6; i++) pulse(8'h00);
        cyc(1'b0, 8'h00, 1'b1);
        chk("t2_ptr_start", 32'(bus.ptr), 32'(0));

        // 2: only requester 2 active -> 1 grant, 7 misses
        for (int unsigned i = 0; i < 8; i++) pulse(8'h04);
        chk("t2_gtotal", 32'(bus.grant_total), 32'(1));
        chk("t2_mtotal", 32'(bus.miss_total),  32'(7));

        // 3: go held high 20 cycles -> single grant to index 0
        for (int unsigned i = 0; i < 20; i++) cyc(1'b1, 8'hFF, 1'b0);
        cyc(1'b0, 8'hFF, 1'b0);
        chk("t3_ptr", 32'(bus.ptr), 32'(1));

        // 4: ptr to 5, then async reset while go high
        for (int unsigned i = 0; i < 4; i++) pulse(8'hFF);
        chk("t4_ptr5", 32'(bus.ptr), 32'(5));
        drive(1'b1, 8'hFF, 1'b0);
        chk("t4_pre_grant", 32'(bus.grant), 32'(8'h20));
        #1;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk_reset_state("t4_rst");
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        predict();
        chk("t4_post_grant", 32'(bus.grant), 32'(8'h01));
        settle();
        cyc(1'b0, 8'hFF, 1'b0);

        // 5: saturation of grant_total, then clear coinciding with a grant
        cyc(1'b0, 8'hFF, 1'b1);
        for (int unsigned i = 0; i < 14; i++) pulse(8'hFF);
        chk("t5_gtotal_14", 32'(bus.grant_total), 32'(14));
        for (int unsigned i = 0; i < 3; i++) pulse(8'hFF);
        chk("t5_gtotal_sat", 32'(bus.grant_total), 32'(15));
        cyc(1'b1, 8'hFF, 1'b1);
        chk("t5_clr_wins", 32'(bus.grant_total), 32'(0));
        cyc(1'b0, 8'h00, 1'b0);
        for (int unsigned i = 0; i < 17; i++) pulse(8'h00);
        chk("t5_mtotal_sat", 32'(bus.miss_total), 32'(15));

        // 6: random go/req/clr against the model
        for (int unsigned i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 1)), N'($urandom), 1'($urandom_range(0, 31) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
